// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, flag-conditioned branches with a one-cycle
// flush bubble, stall hold and sticky halt. All outputs are registered.
module pc_sequencer #(
    parameter int unsigned          PC_W     = 32,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            zero_flag,
    input  logic            carry_flag,
    input  logic            sign_flag,
    input  logic            branch_valid,
    input  logic [3:0]      branch_op,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            taken,
    output logic            illegal_op,
    output logic            halted
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            flush_q, flush_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;
    logic            halted_q, halted_d;
    logic            cond_true;
    logic            op_legal;

    // Condition decode; codes 9-15 are undefined and never taken.
    always_comb begin
        cond_true = 1'b0;
        op_legal  = 1'b1;
        case (branch_op)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = zero_flag;
            4'd2:    cond_true = !zero_flag;
            4'd3:    cond_true = carry_flag;
            4'd4:    cond_true = !carry_flag;
            4'd5:    cond_true = sign_flag;
            4'd6:    cond_true = !sign_flag;
            4'd7:    cond_true = !sign_flag && !zero_flag;
            4'd8:    cond_true = sign_flag || zero_flag;
            default: op_legal  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        taken_d    = 1'b0;
        illegal_d  = 1'b0;
        halted_d   = halted_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d    = ST_HALT;
                        pc_valid_d = 1'b0;
                        halted_d   = 1'b1;
                    end else if (branch_valid && cond_true) begin
                        state_d    = ST_BUBBLE;
                        pc_d       = {target[PC_W-1:2], 2'b00};
                        pc_valid_d = 1'b0;
                        flush_d    = 1'b1;
                        taken_d    = 1'b1;
                    end else begin
                        pc_d      = pc_q + PC_STEP;
                        illegal_d = branch_valid && !op_legal;
                    end
                end
            end
            ST_BUBBLE: begin
                if (!stall) begin
                    state_d    = ST_RUN;
                    pc_valid_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            taken_q    <= taken_d;
            illegal_q  <= illegal_d;
            halted_q   <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign flush      = flush_q;
    assign taken      = taken_q;
    assign illegal_op = illegal_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for control behaviour and an
// 8-bit instance for increment wrap-around.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, RESET_PC = 0
    logic        rst_a = 1'b1, zf_a = 1'b0, cf_a = 1'b0, sf_a = 1'b0;
    logic        bv_a = 1'b0, stall_a = 1'b0, halt_a = 1'b0;
    logic [3:0]  op_a = 4'd0;
    logic [31:0] tgt_a = '0;
    logic [31:0] pc_a;
    logic        pc_valid_a, flush_a, taken_a, illegal_a, halted_a;

    // 8-bit instance, RESET_PC = 0xF8
    logic        rst_b = 1'b1, bv_b = 1'b0, stall_b = 1'b0, halt_b = 1'b0;
    logic [3:0]  op_b = 4'd0;
    logic [7:0]  tgt_b = '0;
    logic [7:0]  pc_b;
    logic        pc_valid_b, flush_b, taken_b, illegal_b, halted_b;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst_a), .zero_flag(zf_a), .carry_flag(cf_a), .sign_flag(sf_a),
        .branch_valid(bv_a), .branch_op(op_a), .target(tgt_a), .stall(stall_a),
        .halt(halt_a), .pc(pc_a), .pc_valid(pc_valid_a), .flush(flush_a), .taken(taken_a),
        .illegal_op(illegal_a), .halted(halted_a)
    );

    pc_sequencer #(.PC_W(8), .RESET_PC(8'hF8)) dut_b (
        .clk(clk), .rst(rst_b), .zero_flag(1'b0), .carry_flag(1'b0), .sign_flag(1'b0),
        .branch_valid(bv_b), .branch_op(op_b), .target(tgt_b), .stall(stall_b),
        .halt(halt_b), .pc(pc_b), .pc_valid(pc_valid_b), .flush(flush_b), .taken(taken_b),
        .illegal_op(illegal_b), .halted(halted_b)
    );

    // {pc, pc_valid, flush, taken, illegal_op, halted}
    wire [36:0] st_a = {pc_a, pc_valid_a, flush_a, taken_a, illegal_a, halted_a};
    wire [12:0] st_b = {pc_b, pc_valid_b, flush_b, taken_b, illegal_b, halted_b};
    logic [36:0] exp_a;
    logic [12:0] exp_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        tick();
        exp_a = {32'h0, 5'b00000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", st_a, exp_a);
        end
    endtask

    task automatic test_free_run();
        rst_a = 1'b0;
        tick();
        exp_a = {32'h0, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL boot_to_run: got %h want %h", st_a, exp_a);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_a = {32'(4 * i), 5'b10000};
            n_tests++;
            if (st_a !== exp_a) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got %h want %h", i, st_a, exp_a);
            end
        end
    endtask

    task automatic test_branch_taken();
        // pc = 0x10 here
        bv_a = 1'b1; op_a = 4'd1; zf_a = 1'b1; tgt_a = 32'h103;
        tick();
        bv_a = 1'b0; zf_a = 1'b0;
        exp_a = {32'h100, 5'b01100};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL bz_taken: got %h want %h", st_a, exp_a);
        end
        tick();
        exp_a = {32'h100, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL bubble_exit: got %h want %h", st_a, exp_a);
        end
        tick();
        exp_a = {32'h104, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL after_branch: got %h want %h", st_a, exp_a);
        end
    endtask

    task automatic test_branch_not_taken();
        // pc = 0x104 here
        bv_a = 1'b1; op_a = 4'd1; zf_a = 1'b0; tgt_a = 32'h103;
        tick();
        exp_a = {32'h108, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL bz_not_taken: got %h want %h", st_a, exp_a);
        end
        op_a = 4'd12;
        tick();
        bv_a = 1'b0;
        exp_a = {32'h10C, 5'b10010};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL illegal_op: got %h want %h", st_a, exp_a);
        end
        tick();
        exp_a = {32'h110, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL illegal_clear: got %h want %h", st_a, exp_a);
        end
    endtask

    task automatic test_bgt();
        // pc = 0x110 here
        bv_a = 1'b1; op_a = 4'd7; sf_a = 1'b0; zf_a = 1'b0; tgt_a = 32'h200;
        tick();
        bv_a = 1'b0;
        exp_a = {32'h200, 5'b01100};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL bgt_taken: got %h want %h", st_a, exp_a);
        end
        tick();
        bv_a = 1'b1; zf_a = 1'b1;
        tick();
        bv_a = 1'b0; zf_a = 1'b0;
        exp_a = {32'h204, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL bgt_not_taken: got %h want %h", st_a, exp_a);
        end
    endtask

    task automatic test_stall_halt();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        repeat (8) tick();
        exp_a = {32'h20, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL reach_0x20: got %h want %h", st_a, exp_a);
        end
        stall_a = 1'b1; halt_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (st_a !== exp_a) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, st_a, exp_a);
            end
        end
        stall_a = 1'b0;
        bv_a = 1'b1; op_a = 4'd0; tgt_a = 32'h300;
        exp_a = {32'h20, 5'b00001};
        for (int i = 0; i < 11; i++) begin
            tick();
            n_tests++;
            if (st_a !== exp_a) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %h want %h", i, st_a, exp_a);
            end
        end
        bv_a = 1'b0; halt_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        bv_a = 1'b1; op_a = 4'd0; tgt_a = 32'h40;
        tick();
        bv_a = 1'b0;
        rst_a = 1'b1;
        tick();
        exp_a = {32'h0, 5'b00000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL rst_in_bubble: got %h want %h", st_a, exp_a);
        end
        rst_a = 1'b0;
        tick();
        exp_a = {32'h0, 5'b10000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL boot_after_rst: got %h want %h", st_a, exp_a);
        end
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        exp_a = {32'h0, 5'b00001};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL halt_enter: got %h want %h", st_a, exp_a);
        end
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        exp_a = {32'h0, 5'b00000};
        n_tests++;
        if (st_a !== exp_a) begin
            n_fail++;
            $display("FAIL rst_in_halt: got %h want %h", st_a, exp_a);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] pcs [4];
        pcs[0] = 8'hF8; pcs[1] = 8'hFC; pcs[2] = 8'h00; pcs[3] = 8'h04;
        rst_b = 1'b1;
        tick();
        exp_b = {8'hF8, 5'b00000};
        n_tests++;
        if (st_b !== exp_b) begin
            n_fail++;
            $display("FAIL wrap_reset: got %h want %h", st_b, exp_b);
        end
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_b = {pcs[i], 5'b10000};
            n_tests++;
            if (st_b !== exp_b) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h want %h", i, st_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch_taken();
        test_branch_not_taken();
        test_bgt();
        test_stall_halt();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
